// File: rtl/market_pkt_rr_arb_pkg.sv
// Shared state encodings, beat layout and default timeout for the market_pkt round-robin arbiter.
package market_arb_pkg;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    localparam int TIMEOUT_DEF = 1024;

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  nbyte;
    } beat_t;
endpackage

// File: rtl/market_pkt_rr_arb_if.sv
// Channel-side and market_pkt-side signal bundle; master drives channel beats, slave is the arbiter.
interface market_pkt_rr_arb_if #(
    parameter int NCH = 4,
    parameter int CHW = 2
);
    logic [NCH-1:0]    ch_mask;
    logic [NCH-1:0]    ch_vld;
    logic [NCH*64-1:0] ch_data;
    logic [NCH-1:0]    ch_sop;
    logic [NCH-1:0]    ch_eop;
    logic [NCH*3-1:0]  ch_byte;
    logic [NCH-1:0]    ch_ready;
    logic              market_pkt_ready;
    logic              market_pkt_vld_o;
    logic [63:0]       market_pkt_data_o;
    logic              market_pkt_sop_o;
    logic              market_pkt_eop_o;
    logic [2:0]        market_pkt_byte_o;
    logic [CHW-1:0]    market_pkt_ch_o;
    logic              abort_o;
    logic              orphan_drop_o;

    modport master (
        output ch_mask, ch_vld, ch_data, ch_sop, ch_eop, ch_byte, market_pkt_ready,
        input  ch_ready, market_pkt_vld_o, market_pkt_data_o, market_pkt_sop_o,
               market_pkt_eop_o, market_pkt_byte_o, market_pkt_ch_o, abort_o, orphan_drop_o
    );

    modport slave (
        input  ch_mask, ch_vld, ch_data, ch_sop, ch_eop, ch_byte, market_pkt_ready,
        output ch_ready, market_pkt_vld_o, market_pkt_data_o, market_pkt_sop_o,
               market_pkt_eop_o, market_pkt_byte_o, market_pkt_ch_o, abort_o, orphan_drop_o
    );
endinterface

// File: rtl/market_pkt_rr_arb_rr_pick.sv
// Rotating-priority encoder: returns the first set req bit scanning upward from last+1 with wrap.
module rr_pick #(
    parameter int NCH = 4,
    parameter int CHW = 2
) (
    input  logic [NCH-1:0] req,
    input  logic [CHW-1:0] last,
    output logic [CHW-1:0] gnt_idx,
    output logic           any_req
);
    int idx;

    always_comb begin
        gnt_idx = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int k = 1; k <= NCH; k++) begin
            idx = (int'(last) + k) % NCH;
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                gnt_idx = CHW'(idx);
            end
        end
    end
endmodule

// File: rtl/market_pkt_rr_arb.sv
// Packet-atomic round-robin arbiter merging NCH channel beat streams into one market_pkt stream.
// Define MARKET_ARB_STAT_EN to add per-channel completed-packet counters (stat_pkt_cnt_o).
module market_pkt_rr_arb
    import market_arb_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CHW     = 2
) (
    input logic clk,
    input logic rst,
    market_pkt_rr_arb_if.slave bus
`ifdef MARKET_ARB_STAT_EN
    ,
    output logic [NCH*32-1:0] stat_pkt_cnt_o
`endif
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [1:0]     state;
    logic [CHW-1:0] grant;
    logic [CHW-1:0] last_grant;
    logic [CW-1:0]  idle_cnt;
    logic           abort_pend;
    logic [NCH-1:0] cand;
    logic [CHW-1:0] pick_idx;
    logic           pick_any;
    logic           gvld;
    beat_t          gbeat;

    assign cand = bus.ch_vld & bus.ch_sop & bus.ch_mask;

    rr_pick #(.NCH(NCH), .CHW(CHW)) u_pick (
        .req     (cand),
        .last    (last_grant),
        .gnt_idx (pick_idx),
        .any_req (pick_any)
    );

    always_comb begin
        gvld        = bus.ch_vld[grant];
        gbeat.data  = bus.ch_data[64*int'(grant) +: 64];
        gbeat.sop   = bus.ch_sop[grant];
        gbeat.eop   = bus.ch_eop[grant];
        gbeat.nbyte = bus.ch_byte[3*int'(grant) +: 3];
    end

    // Outputs are forced low while rst is held so a reset cycle never transfers a beat.
    always_comb begin
        bus.ch_ready          = '0;
        bus.market_pkt_vld_o  = 1'b0;
        bus.market_pkt_data_o = '0;
        bus.market_pkt_sop_o  = 1'b0;
        bus.market_pkt_eop_o  = 1'b0;
        bus.market_pkt_byte_o = '0;
        bus.market_pkt_ch_o   = '0;
        bus.abort_o           = 1'b0;
        bus.orphan_drop_o     = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    bus.ch_ready      = bus.ch_mask & bus.ch_vld & ~bus.ch_sop;
                    bus.orphan_drop_o = |(bus.ch_mask & bus.ch_vld & ~bus.ch_sop);
                end
                GRANT: begin
                    bus.market_pkt_ch_o = grant;
                    if (abort_pend) begin
                        bus.market_pkt_vld_o = 1'b1;
                        bus.market_pkt_eop_o = 1'b1;
                        bus.abort_o          = bus.market_pkt_ready;
                    end else begin
                        bus.market_pkt_vld_o  = gvld;
                        bus.market_pkt_data_o = gbeat.data;
                        bus.market_pkt_sop_o  = gbeat.sop;
                        bus.market_pkt_eop_o  = gbeat.eop;
                        bus.market_pkt_byte_o = gbeat.nbyte;
                        bus.ch_ready[grant]   = bus.market_pkt_ready;
                    end
                end
                FLUSH: begin
                    // A fresh sop is left in place so it can be re-arbitrated from IDLE.
                    bus.ch_ready[grant] = ~(gvld & gbeat.sop);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= CHW'(NCH - 1);
            idle_cnt   <= '0;
            abort_pend <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant      <= pick_idx;
                        state      <= GRANT;
                        idle_cnt   <= '0;
                        abort_pend <= 1'b0;
                    end
                end
                GRANT: begin
                    if (abort_pend) begin
                        if (bus.market_pkt_ready) begin
                            abort_pend <= 1'b0;
                            state      <= FLUSH;
                        end
                    end else if (gvld) begin
                        // Backpressure keeps the counter clear: only a silent channel times out.
                        idle_cnt <= '0;
                        if (bus.market_pkt_ready && gbeat.eop) begin
                            last_grant <= grant;
                            state      <= IDLE;
                        end
                    end else if (idle_cnt == CW'(TIMEOUT - 1)) begin
                        abort_pend <= 1'b1;
                        idle_cnt   <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                FLUSH: begin
                    if (gvld && (gbeat.sop || gbeat.eop)) begin
                        last_grant <= grant;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MARKET_ARB_STAT_EN
    logic [31:0] pkt_cnt [NCH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) pkt_cnt[i] <= '0;
        end else if (state == GRANT && !abort_pend && gvld && bus.market_pkt_ready && gbeat.eop) begin
            pkt_cnt[grant] <= pkt_cnt[grant] + 32'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) stat_pkt_cnt_o[32*i +: 32] = pkt_cnt[i];
    end
`endif
endmodule

// File: tb/tb_market_pkt_rr_arb.sv
// Directed bench for market_pkt_rr_arb: per-channel beat queues feed the DUT, output beats are logged.
module tb_market_pkt_rr_arb;
    logic clk;
    logic rst;

    market_pkt_rr_arb_if #(.NCH(4), .CHW(2)) bus ();

`ifdef MARKET_ARB_STAT_EN
    logic [127:0] stat;
`endif

    market_pkt_rr_arb #(.NCH(4), .TIMEOUT(1024), .CHW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef MARKET_ARB_STAT_EN
        ,
        .stat_pkt_cnt_o (stat)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [68:0] mem [4][16];
    int          hd [4];
    int          tl [4];
    logic [3:0]  mask;
    logic        rdy;

    int          lg_n;
    logic [1:0]  lg_ch   [64];
    logic [63:0] lg_data [64];
    logic        lg_sop  [64];
    logic        lg_eop  [64];
    logic [2:0]  lg_byte [64];
    int          lg_cyc  [64];

    int cyc, aborts, orphans;
    int tests, fails;

    function automatic logic [63:0] dv(input int c, input int p, input int b);
        return 64'hA5A5_0000_0000_0000 + 64'(c * 256 + p * 16 + b);
    endfunction

    task automatic push(input int c, input logic sop, input logic eop, input logic [2:0] nb,
                        input logic [63:0] d);
        if (tl[c] < 16) begin
            mem[c][tl[c]] = {sop, eop, nb, d};
            tl[c]++;
        end
    endtask

    task automatic clear_src();
        for (int c = 0; c < 4; c++) begin
            hd[c] = 0;
            tl[c] = 0;
        end
    endtask

    task automatic drive();
        logic [3:0]   v, s, e;
        logic [255:0] d;
        logic [11:0]  b;
        logic [68:0]  w;
        v = '0; s = '0; e = '0; d = '0; b = '0;
        for (int c = 0; c < 4; c++) begin
            if (hd[c] < tl[c]) begin
                w = mem[c][hd[c]];
                v[c] = 1'b1;
                s[c] = w[68];
                e[c] = w[67];
                b[3*c +: 3]  = w[66:64];
                d[64*c +: 64] = w[63:0];
            end
        end
        bus.ch_vld  = v;
        bus.ch_sop  = s;
        bus.ch_eop  = e;
        bus.ch_data = d;
        bus.ch_byte = b;
        bus.ch_mask = mask;
        bus.market_pkt_ready = rdy;
    endtask

    // Called at a falling edge: present inputs, sample settled outputs, then wait for the next fall.
    task automatic cycle();
        drive();
        #1;
        if (bus.market_pkt_vld_o && bus.market_pkt_ready && lg_n < 64) begin
            lg_ch[lg_n]   = bus.market_pkt_ch_o;
            lg_data[lg_n] = bus.market_pkt_data_o;
            lg_sop[lg_n]  = bus.market_pkt_sop_o;
            lg_eop[lg_n]  = bus.market_pkt_eop_o;
            lg_byte[lg_n] = bus.market_pkt_byte_o;
            lg_cyc[lg_n]  = cyc;
            lg_n++;
        end
        if (bus.abort_o) aborts++;
        if (bus.orphan_drop_o) orphans++;
        for (int c = 0; c < 4; c++)
            if (bus.ch_ready[c] && bus.ch_vld[c]) hd[c]++;
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_until(input int n, input int budget, output logic ok);
        int k;
        k = 0;
        while (lg_n < n && k < budget) begin
            cycle();
            k++;
        end
        ok = (lg_n >= n);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_src();
        mask = 4'hF;
        rdy  = 1'b1;
        drive();
        @(negedge clk);
        rst = 1'b0;
        lg_n = 0; aborts = 0; orphans = 0; cyc = 0;
        drive();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_src();
        mask = 4'hF;
        rdy  = 1'b1;
        push(3, 1'b0, 1'b1, 3'd2, 64'h1234);
        drive();
        #1;
        tests++;
        if (bus.ch_ready !== 4'b0000 || bus.market_pkt_vld_o !== 1'b0 || bus.orphan_drop_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold: ch_ready=%b vld=%b orphan=%b, required 0000/0/0",
                     bus.ch_ready, bus.market_pkt_vld_o, bus.orphan_drop_o);
        end
        @(negedge clk);
        clear_src();
        rst = 1'b0;
        drive();
        #1;
        tests++;
        if ({bus.market_pkt_vld_o, bus.market_pkt_sop_o, bus.market_pkt_eop_o, bus.market_pkt_byte_o,
             bus.market_pkt_data_o, bus.market_pkt_ch_o, bus.abort_o, bus.orphan_drop_o, bus.ch_ready} !== 78'd0) begin
            fails++;
            $display("FAIL reset_outputs: vld=%b sop=%b eop=%b byte=%0d data=%h ch=%0d abort=%b orphan=%b ready=%b, required all 0",
                     bus.market_pkt_vld_o, bus.market_pkt_sop_o, bus.market_pkt_eop_o, bus.market_pkt_byte_o,
                     bus.market_pkt_data_o, bus.market_pkt_ch_o, bus.abort_o, bus.orphan_drop_o, bus.ch_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic ok;
        int   pk, c, p, b;
        do_reset();
        for (int pp = 0; pp < 3; pp++)
            for (int cc = 0; cc < 4; cc++) begin
                push(cc, 1'b1, 1'b0, 3'd0, dv(cc, pp, 0));
                push(cc, 1'b0, 1'b1, 3'(cc + 1), dv(cc, pp, 1));
            end
        run_until(24, 200, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL rr_timeout: got %0d beats, required 24", lg_n);
        end
        for (int k = 0; k < 24; k++) begin
            pk = k / 2; c = pk % 4; p = pk / 4; b = k % 2;
            tests++;
            if ({lg_ch[k], lg_sop[k], lg_eop[k], lg_byte[k], lg_data[k]} !==
                {2'(c), (b == 0), (b == 1), (b == 1) ? 3'(c + 1) : 3'd0, dv(c, p, b)}) begin
                fails++;
                $display("FAIL rr_beat%0d: ch=%0d sop=%b eop=%b byte=%0d data=%h, required ch=%0d data=%h",
                         k, lg_ch[k], lg_sop[k], lg_eop[k], lg_byte[k], lg_data[k], c, dv(c, p, b));
            end
        end
        tests++;
        if (lg_cyc[0] !== 1) begin
            fails++;
            $display("FAIL rr_first_latency: first beat cycle %0d, required 1", lg_cyc[0]);
        end
        for (int q = 0; q < 12; q++) begin
            tests++;
            if (lg_cyc[2*q+1] - lg_cyc[2*q] !== 1 || (q < 11 && lg_cyc[2*q+2] - lg_cyc[2*q+1] !== 2)) begin
                fails++;
                $display("FAIL rr_spacing_pkt%0d: intra=%0d inter=%0d, required 1 and 2", q,
                         lg_cyc[2*q+1] - lg_cyc[2*q], (q < 11) ? lg_cyc[2*q+2] - lg_cyc[2*q+1] : 2);
            end
        end
    endtask

    task automatic test_atomicity();
        logic ok;
        do_reset();
        for (int b = 0; b < 5; b++)
            push(1, b == 0, b == 4, (b == 4) ? 3'd5 : 3'd0, dv(1, 0, b));
        cycle();
        push(0, 1'b1, 1'b1, 3'd1, dv(0, 0, 0));
        push(2, 1'b1, 1'b1, 3'd0, dv(2, 0, 0));
        run_until(7, 100, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL atom_timeout: got %0d beats, required 7", lg_n);
        end
        for (int b = 0; b < 5; b++) begin
            tests++;
            if ({lg_ch[b], lg_sop[b], lg_eop[b], lg_data[b]} !== {2'd1, (b == 0), (b == 4), dv(1, 0, b)}) begin
                fails++;
                $display("FAIL atom_beat%0d: ch=%0d sop=%b eop=%b data=%h, required ch=1 data=%h",
                         b, lg_ch[b], lg_sop[b], lg_eop[b], lg_data[b], dv(1, 0, b));
            end
        end
        tests++;
        if (lg_cyc[4] - lg_cyc[0] !== 4) begin
            fails++;
            $display("FAIL atom_contiguous: span %0d cycles, required 4", lg_cyc[4] - lg_cyc[0]);
        end
        tests++;
        if ({lg_ch[5], lg_data[5], lg_ch[6], lg_data[6]} !== {2'd2, dv(2, 0, 0), 2'd0, dv(0, 0, 0)}) begin
            fails++;
            $display("FAIL atom_next_grants: got ch%0d then ch%0d, required ch2 then ch0", lg_ch[5], lg_ch[6]);
        end
    endtask

    task automatic test_backpressure();
        logic ok;
        do_reset();
        for (int b = 0; b < 4; b++)
            push(0, b == 0, b == 3, (b == 3) ? 3'd4 : 3'd0, dv(0, 3, b));
        run_until(2, 50, ok);
        rdy = 1'b0;
        repeat (2000) cycle();
        drive();
        #1;
        tests++;
        if ({bus.market_pkt_vld_o, bus.market_pkt_data_o, bus.ch_ready, lg_n[7:0], aborts[7:0]} !==
            {1'b1, dv(0, 3, 2), 4'b0000, 8'd2, 8'd0}) begin
            fails++;
            $display("FAIL bp_stall: vld=%b data=%h ready=%b beats=%0d aborts=%0d, required 1/%h/0000/2/0",
                     bus.market_pkt_vld_o, bus.market_pkt_data_o, bus.ch_ready, lg_n, aborts, dv(0, 3, 2));
        end
        @(negedge clk);
        rdy = 1'b1;
        run_until(4, 50, ok);
        tests++;
        if (!ok || {lg_data[2], lg_data[3], lg_eop[3], lg_byte[3]} !== {dv(0, 3, 2), dv(0, 3, 3), 1'b1, 3'd4}
            || aborts !== 0) begin
            fails++;
            $display("FAIL bp_resume: beats=%0d data2=%h data3=%h aborts=%0d, required 4/%h/%h/0",
                     lg_n, lg_data[2], lg_data[3], aborts, dv(0, 3, 2), dv(0, 3, 3));
        end
    endtask

    task automatic test_timeout();
        logic ok;
        do_reset();
        for (int b = 0; b < 3; b++)
            push(0, b == 0, 1'b0, 3'd0, dv(0, 5, b));
        run_until(3, 50, ok);
        run_until(4, 1100, ok);
        tests++;
        if (!ok || {lg_ch[3], lg_sop[3], lg_eop[3], lg_byte[3], lg_data[3]} !== {2'd0, 1'b0, 1'b1, 3'd0, 64'd0}) begin
            fails++;
            $display("FAIL to_synthetic: beats=%0d ch=%0d sop=%b eop=%b byte=%0d data=%h, required ch0 sop0 eop1 byte0 data0",
                     lg_n, lg_ch[3], lg_sop[3], lg_eop[3], lg_byte[3], lg_data[3]);
        end
        tests++;
        if (lg_cyc[3] - lg_cyc[2] !== 1025) begin
            fails++;
            $display("FAIL to_delay: abort beat %0d cycles after last beat, required 1025", lg_cyc[3] - lg_cyc[2]);
        end
        tests++;
        if (aborts !== 1) begin
            fails++;
            $display("FAIL to_abort_pulse: %0d pulses, required 1", aborts);
        end
        for (int b = 3; b < 6; b++)
            push(0, 1'b0, b == 5, (b == 5) ? 3'd2 : 3'd0, dv(0, 5, b));
        repeat (10) cycle();
        tests++;
        if (hd[0] !== 6 || lg_n !== 4 || orphans !== 0 || aborts !== 1) begin
            fails++;
            $display("FAIL to_flush: consumed=%0d beats=%0d orphans=%0d aborts=%0d, required 6/4/0/1",
                     hd[0], lg_n, orphans, aborts);
        end
        push(1, 1'b1, 1'b1, 3'd3, dv(1, 6, 0));
        run_until(5, 20, ok);
        tests++;
        if (!ok || {lg_ch[4], lg_sop[4], lg_data[4]} !== {2'd1, 1'b1, dv(1, 6, 0)}) begin
            fails++;
            $display("FAIL to_back_idle: beats=%0d ch=%0d data=%h, required ch1 data=%h",
                     lg_n, lg_ch[4], lg_data[4], dv(1, 6, 0));
        end
    endtask

    task automatic test_orphan_mask();
        logic ok;
        do_reset();
        mask = 4'b1101;
        push(3, 1'b0, 1'b1, 3'd1, dv(3, 7, 1));
        push(1, 1'b1, 1'b1, 3'd0, dv(1, 7, 0));
        repeat (20) cycle();
        tests++;
        if (orphans !== 1 || hd[3] !== 1 || lg_n !== 0) begin
            fails++;
            $display("FAIL orphan_drop: pulses=%0d consumed=%0d out_beats=%0d, required 1/1/0", orphans, hd[3], lg_n);
        end
        tests++;
        if (hd[1] !== 0) begin
            fails++;
            $display("FAIL mask_block: ch1 consumed %0d beats, required 0", hd[1]);
        end
        mask = 4'b1111;
        run_until(1, 10, ok);
        tests++;
        if (!ok || lg_ch[0] !== 2'd1) begin
            fails++;
            $display("FAIL mask_release: beats=%0d ch=%0d, required ch1", lg_n, lg_ch[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic ok;
        int   c0;
        do_reset();
        for (int b = 0; b < 6; b++)
            push(2, b == 0, b == 5, 3'd0, dv(2, 8, b));
        run_until(2, 50, ok);
        rst = 1'b1;
        drive();
        #1;
        tests++;
        if (bus.market_pkt_vld_o !== 1'b0 || bus.ch_ready !== 4'b0000) begin
            fails++;
            $display("FAIL rstmid_hold: vld=%b ready=%b, required 0/0000", bus.market_pkt_vld_o, bus.ch_ready);
        end
        @(negedge clk);
        clear_src();
        rst = 1'b0;
        drive();
        #1;
        tests++;
        if ({bus.market_pkt_vld_o, bus.market_pkt_sop_o, bus.market_pkt_eop_o, bus.market_pkt_data_o,
             bus.abort_o, bus.orphan_drop_o, bus.ch_ready} !== 73'd0) begin
            fails++;
            $display("FAIL rstmid_outputs: vld=%b data=%h abort=%b orphan=%b ready=%b, required all 0",
                     bus.market_pkt_vld_o, bus.market_pkt_data_o, bus.abort_o, bus.orphan_drop_o, bus.ch_ready);
        end
        @(negedge clk);
        push(2, 1'b1, 1'b0, 3'd0, dv(2, 9, 0));
        push(2, 1'b0, 1'b1, 3'd6, dv(2, 9, 1));
        c0 = cyc;
        run_until(4, 20, ok);
        tests++;
        if (!ok || {lg_ch[2], lg_sop[2], lg_data[2], lg_data[3], lg_eop[3]} !==
            {2'd2, 1'b1, dv(2, 9, 0), dv(2, 9, 1), 1'b1} || lg_cyc[2] !== c0 + 1) begin
            fails++;
            $display("FAIL rstmid_regrant: beats=%0d ch=%0d sop=%b data=%h at cycle %0d, required ch2 sop data=%h at cycle %0d",
                     lg_n, lg_ch[2], lg_sop[2], lg_data[2], lg_cyc[2], dv(2, 9, 0), c0 + 1);
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        lg_n = 0; cyc = 0; aborts = 0; orphans = 0;
        rst = 1'b1; mask = 4'hF; rdy = 1'b1;
        clear_src();
        test_reset();
        test_round_robin();
        test_atomicity();
        test_backpressure();
        test_timeout();
        test_orphan_mask();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
